// File: rtl/mem_pkg.sv
// mem_pkg: shared line geometry and FSM state encoding for block_data_memory.
// Revision: 1.0
`default_nettype none

package mem_pkg;

  localparam int BLOCK_BITS      = 128;
  localparam int BYTES_PER_BLOCK = 16;

  typedef logic [BLOCK_BITS-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/block_ram_array.sv
// block_ram_array: 128-bit line storage, byte-enabled synchronous write, registered read.
// Revision: 1.0
`default_nettype none

module block_ram_array
  import mem_pkg::*;
#(
  parameter int NUM_BLOCKS = 64,
  parameter int ADDR_BITS  = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_we,
  input  logic                       i_re,
  input  logic [ADDR_BITS-1:0]       i_addr,
  input  logic [BLOCK_BITS-1:0]      i_wdata,
  input  logic [BYTES_PER_BLOCK-1:0] i_be,
  output logic [BLOCK_BITS-1:0]      o_rdata
);

  block_t r_mem [NUM_BLOCKS];
  block_t r_rdata;

  // Storage is deliberately not reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BYTES_PER_BLOCK; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/block_data_memory.sv
// block_data_memory: 64 x 128-bit line memory with request/ready handshake and LATENCY-cycle access.
// Optional MEM_BYTE_MASK_EN adds a per-byte write mask input. Revision: 1.0
`default_nettype none

module block_data_memory
  import mem_pkg::*;
#(
  parameter int LATENCY    = 1,
  parameter int NUM_BLOCKS = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mem_req,
  input  logic                          mem_write,
  input  logic [$clog2(NUM_BLOCKS)-1:0] block_addr,
  input  logic [127:0]                  wdata,
`ifdef MEM_BYTE_MASK_EN
  input  logic [15:0]                   wmask,
`endif
  output logic [127:0]                  rdata,
  output logic                          mem_ready,
  output logic                          busy
);

  localparam int         c_AW       = $clog2(NUM_BLOCKS);
  localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

  mem_state_t                 r_state;
  mem_state_t                 w_state_nxt;
  logic [3:0]                 r_cnt;
  logic                       r_write;
  logic [c_AW-1:0]            r_addr;
  block_t                     r_wdata;
  logic                       r_mem_ready;
  logic                       r_busy;
  logic                       w_accept;
  logic                       w_access;
  logic                       w_we;
  logic                       w_re;
  logic [BYTES_PER_BLOCK-1:0] w_be;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (mem_req) w_state_nxt = BUSY;
      BUSY:    if (r_cnt == 4'd0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A reset in the commit cycle must suppress the write, hence rst_n in w_we.
  always_comb begin
    w_accept = (r_state == IDLE) && mem_req;
    w_access = (r_state == BUSY) && (r_cnt == 4'd0);
    w_we     = w_access && r_write && rst_n;
    w_re     = w_access && !r_write;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= 4'd0;
      r_mem_ready <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= c_CNT_INIT;
      end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_mem_ready <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= mem_write;
      r_addr  <= block_addr;
      r_wdata <= wdata;
    end
  end

`ifdef MEM_BYTE_MASK_EN
  logic [BYTES_PER_BLOCK-1:0] r_wmask;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wmask <= wmask;
    end
  end

  assign w_be = r_wmask;
`else
  assign w_be = '1;
`endif

  block_ram_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .ADDR_BITS  (c_AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .i_be    (w_be),
    .o_rdata (rdata)
  );

  assign mem_ready = r_mem_ready;
  assign busy      = r_busy;

endmodule

`default_nettype wire
